// File: rtl/ram_port_client.sv
`timescale 1ns/1ps
// ram_port_client
//   Initiator-side controller for one port of a true dual-port RAM that has
//   a 1-cycle read latency. After reset it writes INIT_VALUE to every
//   address. It then turns a valid/ready request channel into RAM port
//   strobes, and returns read data through a response FIFO. A credit check
//   keeps that FIFO from ever overflowing.
//
// Handshake rule for both channels: a transfer happens at a rising clk edge
//   exactly when valid and ready are both high. valid never waits on ready.
//   req_rdy may depend combinationally on req_we, because writes never need
//   credit.
//
// Ports
//   clk, rst_n         clock and synchronous active-low reset
//   init_done          high once the clear sweep has completed
//   req_val/req_rdy    request handshake; req_we, req_addr, req_wdata qualify it
//   rsp_val/rsp_rdy    read-response handshake; rsp_rdata is the FIFO head
//   ram_en, ram_we, ram_addr, ram_din  strobes to the RAM port
//   ram_dout           RAM read data, valid only in the cycle after a read strobe
//   state_dbg          FSM state (0 = INIT sweep, 1 = RUN)
module ram_port_client #(
  parameter int RAM_DEPTH      = 16,
  parameter int RAM_ADDR_WIDTH = 4,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RSP_DEPTH      = 4,
  parameter logic [RAM_DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      init_done,
  input  logic                      req_val,
  output logic                      req_rdy,
  input  logic                      req_we,
  input  logic [RAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [RAM_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_val,
  input  logic                      rsp_rdy,
  output logic [RAM_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] ram_din,
  input  logic [RAM_DATA_WIDTH-1:0] ram_dout,
  output logic                      state_dbg
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR  = RAM_ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [CNT_W:0]            CREDIT_MAX = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0]          FIFO_FULL  = CNT_W'(RSP_DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    state;
  logic [RAM_ADDR_WIDTH-1:0] init_cnt;
  logic                      rd_pend;
  logic [RAM_DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          fifo_cnt;
  logic                      credit_ok;
  logic                      req_acc;
  logic                      push;
  logic                      pop;

  // Every queued response and every read still in the RAM pipeline holds
  // one FIFO slot. Only the registered count is used here, so a pop in
  // the same cycle does not free a slot until the next cycle.
  assign credit_ok = ({1'b0, fifo_cnt} + {{CNT_W{1'b0}}, rd_pend}) < CREDIT_MAX;
  assign req_rdy   = (state == ST_RUN) && (req_we || credit_ok);
  assign req_acc   = req_val && req_rdy;

  // ram_dout is captured only in the cycle after a read strobe.
  assign push      = rd_pend;
  assign rsp_val   = (fifo_cnt != '0);
  assign pop       = rsp_val && rsp_rdy;
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign state_dbg = (state == ST_RUN);

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = req_addr;
    ram_din  = req_wdata;
    if (state == ST_INIT) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = init_cnt;
      ram_din  = INIT_VALUE;
    end else begin
      ram_en   = req_acc;
      ram_we   = req_we;
    end
  end

  // Control FSM. init_cnt stops at the last address, so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          rd_pend <= 1'b0;
          if (init_cnt == LAST_ADDR) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          rd_pend <= req_acc && !req_we;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // FIFO pointers and occupancy count. Pointers wrap naturally because
  // RSP_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage has no reset. Entries are only read after they are written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_dout;
  end

  // The credit check guarantees that no push ever arrives while the FIFO is full.
  a_no_push_on_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_cnt == FIFO_FULL));

endmodule

// File: tb/tb_ram_port_client.sv
`timescale 1ns/1ps
// tb_ram_port_client
//   Bench for ram_port_client with RAM_DEPTH=16, RSP_DEPTH=4 and 32-bit data.
//   It contains a behavioural RAM attached to the DUT port. A shadow memory
//   predicts read data at the moment each request is accepted, and the
//   prediction is pushed onto exp_q. A separate monitor compares rsp_rdata
//   with the head of exp_q, and pops the head when a response is handed over.
module tb_ram_port_client;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int RSPD  = 4;
  localparam logic [DW-1:0] INIT_V = 32'h0000_0000;
  localparam logic [DW-1:0] POISON = 32'hA5A5_5A5A;

  logic          clk;
  logic          rst_n;
  logic          init_done;
  logic          req_val;
  logic          req_rdy;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_val;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          state_dbg;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_port_client #(
    .RAM_DEPTH(DEPTH), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW),
    .RSP_DEPTH(RSPD), .INIT_VALUE(INIT_V)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .req_val(req_val), .req_rdy(req_rdy), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .state_dbg(state_dbg)
  );

  // ---------------- behavioural RAM port (1-cycle read latency) ----------------
  // Read data is visible only in the cycle after a read strobe. At all
  // other times the port drives a poison word.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_q;
  logic          ram_q_ok = 1'b0;

  always @(posedge clk) begin
    ram_q_ok <= ram_en && !ram_we;
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_q <= ram_mem[ram_addr];
    end
  end
  assign ram_dout = ram_q_ok ? ram_q : POISON;

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic          rdy_level = 1'b0;
  logic          rand_rdy  = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of request stimulus at the falling edge. It reads
  // req_rdy 1 ns later. An accepted request updates the shadow memory
  // (for a write) or queues the predicted read data (for a read).
  task automatic do_req(input logic val, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output logic acc);
    @(negedge clk);
    rsp_rdy   = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
    req_val   = val;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    acc = req_val && req_rdy;
    if (acc) begin
      if (we) ref_mem[addr] = wdata;
      else    exp_q.push_back(ref_mem[addr]);
    end
  endtask

  task automatic do_idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) do_req(1'b0, 1'b0, '0, '0, acc);
  endtask

  task automatic drain();
    logic acc;
    rand_rdy  = 1'b0;
    rdy_level = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) do_req(1'b0, 1'b0, '0, '0, acc);
    check("drain_empty", DW'(exp_q.size()), '0);
  endtask

  // Holds reset for one rising edge, then checks the full clear sweep.
  task automatic do_reset_sweep();
    @(negedge clk);
    rst_n   = 1'b0;
    req_val = 1'b0;
    req_we  = 1'b0;
    rsp_rdy = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_V;
    @(negedge clk);
    #1;
    check("rst_init_done", init_done, 1'b0);
    check("rst_req_rdy", req_rdy, 1'b0);
    check("rst_rsp_val", rsp_val, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("sweep_en", ram_en, 1'b1);
      check("sweep_we", ram_we, 1'b1);
      check("sweep_addr", DW'(ram_addr), DW'(i));
      check("sweep_din", ram_din, INIT_V);
      check("sweep_req_rdy", req_rdy, 1'b0);
      check("sweep_init_done", init_done, 1'b0);
      check("sweep_state", state_dbg, 1'b0);
      @(negedge clk);
      #1;
    end
    check("post_sweep_init_done", init_done, 1'b1);
    check("post_sweep_req_rdy", req_rdy, 1'b1);
    check("post_sweep_ram_en", ram_en, 1'b0);
    check("post_sweep_state", state_dbg, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && rsp_val) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_unexpected: got rsp_val with data %h, no response expected", rsp_rdata);
        end else begin
          check("rsp_rdata", rsp_rdata, exp_q[0]);
          if (rsp_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   acc_cnt;
    int   a;
    rst_n = 1'b0; req_val = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_rdy = 1'b0;

    // Reset and clear sweep, then read addr 7, which must return INIT_V.
    do_reset_sweep();
    rdy_level = 1'b1;
    do_req(1'b1, 1'b0, 4'd7, '0, acc);
    check("rd7_acc", acc, 1'b1);
    drain();

    // Write then read the same address on back-to-back cycles. Check the 2-cycle latency.
    do_req(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, acc);
    check("wr_acc", acc, 1'b1);
    check("wr_ram_en", ram_en, 1'b1);
    check("wr_ram_we", ram_we, 1'b1);
    check("wr_ram_addr", DW'(ram_addr), 32'd3);
    check("wr_ram_din", ram_din, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 4'd3, '0, acc);
    check("rd_after_wr_acc", acc, 1'b1);
    do_idle(1);
    check("lat_rsp_val_c1", rsp_val, 1'b0);
    do_idle(1);
    check("lat_rsp_val_c2", rsp_val, 1'b1);
    drain();

    // Fill the RAM with random contents.
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 1'b1, AW'(i), $urandom(), acc);

    // Backpressure: with no responses being taken, only RSP_DEPTH reads are accepted.
    rdy_level = 1'b0;
    acc_cnt = 0;
    a = 0;
    for (int c = 0; c < 8; c++) begin
      do_req(1'b1, 1'b0, AW'(a), '0, acc);
      if (acc) begin acc_cnt++; a++; end
    end
    check("bp_accepts", DW'(acc_cnt), DW'(RSPD));
    check("bp_read_rdy", req_rdy, 1'b0);
    do_req(1'b1, 1'b1, 4'd12, $urandom(), acc);
    check("bp_write_acc", acc, 1'b1);
    rdy_level = 1'b1;
    for (int c = 0; c < 20 && a < 6; c++) begin
      do_req(1'b1, 1'b0, AW'(a), '0, acc);
      if (acc) a++;
    end
    check("bp_rest_accepted", DW'(a), 32'd6);
    drain();

    // Streaming: 20 back-to-back reads with rsp_rdy held high, one per cycle.
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      do_req(1'b1, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0, acc);
      if (acc) acc_cnt++;
    end
    check("stream_accepts", DW'(acc_cnt), 32'd20);
    drain();

    // Push and pop in the same cycle with 2 entries queued. The count stays
    // at 2, so exactly 2 more reads fit.
    rdy_level = 1'b0;
    do_req(1'b1, 1'b0, 4'd1, '0, acc);
    do_req(1'b1, 1'b0, 4'd2, '0, acc);
    do_idle(2);
    do_req(1'b1, 1'b0, 4'd3, '0, acc);
    check("pp_third_acc", acc, 1'b1);
    rdy_level = 1'b1;
    do_idle(1);
    rdy_level = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      do_req(1'b1, 1'b0, AW'(4 + acc_cnt), '0, acc);
      if (acc) acc_cnt++;
    end
    check("pp_credit", DW'(acc_cnt), 32'd2);
    drain();

    // Reset while 3 responses are queued. They must all disappear.
    rdy_level = 1'b0;
    for (int i = 0; i < 3; i++) do_req(1'b1, 1'b0, AW'(8 + i), '0, acc);
    do_idle(2);
    check("pre_rst_rsp_val", rsp_val, 1'b1);
    do_reset_sweep();
    rdy_level = 1'b1;
    do_idle(3);
    check("post_rst_no_rsp", rsp_val, 1'b0);

    // Random mix of reads and writes, with random response backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++)
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, DEPTH - 1)), $urandom(), acc);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
